// File: rtl/lab2_proc_hazard_unit.sv
// Hazard, stall and bypass controller for the 5-stage TinyRV2 pipeline.
// Define LAB2_PROC_HAZARD_BYPASS_EN for full bypassing; otherwise RAW hazards stall until writeback.
module lab2_proc_hazard_unit #(
    parameter int p_nregs_log2 = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    val_D,
    input  logic                    rs1_en_D,
    input  logic                    rs2_en_D,
    input  logic [p_nregs_log2-1:0] rs1_D,
    input  logic [p_nregs_log2-1:0] rs2_D,
    input  logic [p_nregs_log2-1:0] rd_D,
    input  logic                    wen_D,
    input  logic                    is_load_D,
    input  logic                    is_mul_D,
    input  logic                    squash_D,
    input  logic                    stall_M,
    input  logic                    imul_req_rdy_D,
    input  logic                    imul_resp_val_X,
    output logic                    stall_D,
    output logic [1:0]              bypass_rs1_sel,
    output logic [1:0]              bypass_rs2_sel,
    output logic                    imul_req_val_D,
    output logic                    imul_resp_rdy_X,
    output logic                    reg_en_X,
    output logic                    reg_en_M,
    output logic                    val_X,
    output logic                    val_M,
    output logic                    val_W,
    output logic                    rf_wen_W,
    output logic [p_nregs_log2-1:0] rf_waddr_W
);

    logic                    val_X_q, wen_X_q, is_load_X_q, is_mul_X_q;
    logic                    val_X_d, wen_X_d, is_load_X_d, is_mul_X_d;
    logic [p_nregs_log2-1:0] rd_X_q, rd_X_d;
    logic                    val_M_q, wen_M_q, val_M_d, wen_M_d;
    logic [p_nregs_log2-1:0] rd_M_q, rd_M_d;
    logic                    val_W_q, wen_W_q, val_W_d, wen_W_d;
    logic [p_nregs_log2-1:0] rd_W_q, rd_W_d;

    logic stall_X, stall_hz, hz_raw, mul_busy;
    logic m1_X, m1_M, m1_W, m2_X, m2_M, m2_W;

    function automatic logic src_match(input logic en, input logic [p_nregs_log2-1:0] rs,
                                       input logic v, input logic w,
                                       input logic [p_nregs_log2-1:0] rd);
        return en & (rs != '0) & v & w & (rd == rs);
    endfunction

`ifdef LAB2_PROC_HAZARD_BYPASS_EN
    function automatic logic [1:0] pick(input logic mx, input logic mm, input logic mw);
        if (mx)      return 2'd1;
        else if (mm) return 2'd2;
        else if (mw) return 2'd3;
        else         return 2'd0;
    endfunction
`endif

    always_comb begin
        stall_X = (val_X_q & is_mul_X_q & ~imul_resp_val_X) | stall_M;

        m1_X = src_match(rs1_en_D, rs1_D, val_X_q, wen_X_q, rd_X_q);
        m1_M = src_match(rs1_en_D, rs1_D, val_M_q, wen_M_q, rd_M_q);
        m1_W = src_match(rs1_en_D, rs1_D, val_W_q, wen_W_q, rd_W_q);
        m2_X = src_match(rs2_en_D, rs2_D, val_X_q, wen_X_q, rd_X_q);
        m2_M = src_match(rs2_en_D, rs2_D, val_M_q, wen_M_q, rd_M_q);
        m2_W = src_match(rs2_en_D, rs2_D, val_W_q, wen_W_q, rd_W_q);

`ifdef LAB2_PROC_HAZARD_BYPASS_EN
        hz_raw         = (m1_X | m2_X) & is_load_X_q;
        bypass_rs1_sel = pick(m1_X, m1_M, m1_W);
        bypass_rs2_sel = pick(m2_X, m2_M, m2_W);
`else
        // The W match is needed because the register file only writes at the clock edge.
        hz_raw         = m1_X | m1_M | m1_W | m2_X | m2_M | m2_W | ((m1_X | m2_X) & is_load_X_q);
        bypass_rs1_sel = '0;
        bypass_rs2_sel = '0;
`endif

        mul_busy        = is_mul_D & ~imul_req_rdy_D;
        stall_hz        = val_D & ~squash_D & (stall_X | hz_raw);
        stall_D         = val_D & ~squash_D & (stall_X | hz_raw | mul_busy);
        imul_req_val_D  = val_D & is_mul_D & ~squash_D & ~stall_hz;
        imul_resp_rdy_X = val_X_q & is_mul_X_q & ~stall_M;
        reg_en_X        = ~stall_X;
        reg_en_M        = ~stall_M;
        val_X           = val_X_q;
        val_M           = val_M_q;
        val_W           = val_W_q;
        rf_wen_W        = val_W_q & wen_W_q & (rd_W_q != '0);
        rf_waddr_W      = rd_W_q;
    end

    always_comb begin
        val_X_d     = val_X_q;
        rd_X_d      = rd_X_q;
        wen_X_d     = wen_X_q;
        is_load_X_d = is_load_X_q;
        is_mul_X_d  = is_mul_X_q;
        if (!stall_X) begin
            val_X_d     = val_D & ~stall_D & ~squash_D;
            rd_X_d      = rd_D;
            wen_X_d     = wen_D;
            is_load_X_d = is_load_D;
            is_mul_X_d  = is_mul_D;
        end

        val_M_d = val_M_q;
        rd_M_d  = rd_M_q;
        wen_M_d = wen_M_q;
        if (!stall_M) begin
            val_M_d = val_X_q & ~stall_X;
            rd_M_d  = rd_X_q;
            wen_M_d = wen_X_q;
        end

        val_W_d = val_M_q & ~stall_M;
        rd_W_d  = rd_M_q;
        wen_W_d = wen_M_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_X_q     <= 1'b0;
            rd_X_q      <= '0;
            wen_X_q     <= 1'b0;
            is_load_X_q <= 1'b0;
            is_mul_X_q  <= 1'b0;
            val_M_q     <= 1'b0;
            rd_M_q      <= '0;
            wen_M_q     <= 1'b0;
            val_W_q     <= 1'b0;
            rd_W_q      <= '0;
            wen_W_q     <= 1'b0;
        end else begin
            val_X_q     <= val_X_d;
            rd_X_q      <= rd_X_d;
            wen_X_q     <= wen_X_d;
            is_load_X_q <= is_load_X_d;
            is_mul_X_q  <= is_mul_X_d;
            val_M_q     <= val_M_d;
            rd_M_q      <= rd_M_d;
            wen_M_q     <= wen_M_d;
            val_W_q     <= val_W_d;
            rd_W_q      <= rd_W_d;
            wen_W_q     <= wen_W_d;
        end
    end

endmodule

// File: tb/tb_lab2_proc_hazard_unit.sv
// Self-checking bench for lab2_proc_hazard_unit: directed cycle tables plus randomized model comparison.
module tb_lab2_proc_hazard_unit;

    localparam int N = 5;
`ifdef LAB2_PROC_HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam bit [8:0] RS1 = 9'h100, RS2 = 9'h080, WEN = 9'h040, LD = 9'h020, MUL = 9'h010;
    localparam bit [8:0] SQ  = 9'h008, STM = 9'h004, RDY = 9'h002, RSP = 9'h001;

    logic clk = 1'b0;
    logic reset, val_D, rs1_en_D, rs2_en_D, wen_D, is_load_D, is_mul_D, squash_D;
    logic stall_M, imul_req_rdy_D, imul_resp_val_X;
    logic [N-1:0] rs1_D, rs2_D, rd_D;
    logic stall_D, imul_req_val_D, imul_resp_rdy_X, reg_en_X, reg_en_M;
    logic val_X, val_M, val_W, rf_wen_W;
    logic [1:0] bypass_rs1_sel, bypass_rs2_sel;
    logic [N-1:0] rf_waddr_W;

    lab2_proc_hazard_unit #(.p_nregs_log2(N)) dut (
        .clk(clk), .reset(reset), .val_D(val_D), .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .wen_D(wen_D), .is_load_D(is_load_D),
        .is_mul_D(is_mul_D), .squash_D(squash_D), .stall_M(stall_M),
        .imul_req_rdy_D(imul_req_rdy_D), .imul_resp_val_X(imul_resp_val_X),
        .stall_D(stall_D), .bypass_rs1_sel(bypass_rs1_sel), .bypass_rs2_sel(bypass_rs2_sel),
        .imul_req_val_D(imul_req_val_D), .imul_resp_rdy_X(imul_resp_rdy_X),
        .reg_en_X(reg_en_X), .reg_en_M(reg_en_M), .val_X(val_X), .val_M(val_M), .val_W(val_W),
        .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit val, input int rs1, input int rs2,
                         input int rd, input bit [8:0] fl);
        reset           = rst;
        val_D           = val;
        rs1_D           = 5'(rs1);
        rs2_D           = 5'(rs2);
        rd_D            = 5'(rd);
        rs1_en_D        = fl[8];
        rs2_en_D        = fl[7];
        wen_D           = fl[6];
        is_load_D       = fl[5];
        is_mul_D        = fl[4];
        squash_D        = fl[3];
        stall_M         = fl[2];
        imul_req_rdy_D  = fl[1];
        imul_resp_val_X = fl[0];
    endtask

    typedef struct {
        bit       rst;
        bit       val;
        bit [4:0] rs1, rs2, rd;
        bit [8:0] fl;
        bit       st;
        bit [1:0] s1, s2;
        bit       req, rrdy;
        bit [1:0] en;
        bit [2:0] v;
        bit       rfw;
        bit [4:0] wa;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit val, int rs1, int rs2, int rd, bit [8:0] fl, bit st,
                                int s1, int s2, bit req, bit rrdy, bit [1:0] en, bit [2:0] v,
                                bit rfw, int wa);
        vec_t r;
        r.rst = rst; r.val = val; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd); r.fl = fl;
        r.st = st; r.s1 = 2'(s1); r.s2 = 2'(s2); r.req = req; r.rrdy = rrdy; r.en = en;
        r.v = v; r.rfw = rfw; r.wa = 5'(wa);
        vecs.push_back(r);
    endfunction

    function automatic void idl(bit [8:0] fl, bit rrdy, bit [2:0] v, bit rfw, int wa);
        add(0, 0, 0, 0, 0, fl, 0, 0, 0, 0, rrdy, 2'b11, v, rfw, wa);
    endfunction

    // Pipeline model: index 0 = X, 1 = M, 2 = W.
    typedef struct { bit v; int rd; bit wen; bit ld; bit mul; } slot_t;
    slot_t pipe[3];
    slot_t bubble = '{0, 0, 0, 0, 0};

    initial begin
        int sel_e[2];
        int rs_a[2];
        bit en_a[2];
        bit stx, hz, ld_hz, any_hz, std_e, sthz_e, req_e, enter_e;
        slot_t dslot;
        slot_t nxt[3];

        drive(1, 0, 0, 0, 0, 9'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall_D", int'(stall_D), 0);
        chk("rst_sel1", int'(bypass_rs1_sel), 0);
        chk("rst_sel2", int'(bypass_rs2_sel), 0);
        chk("rst_req_val", int'(imul_req_val_D), 0);
        chk("rst_resp_rdy", int'(imul_resp_rdy_X), 0);
        chk("rst_vals", int'({val_X, val_M, val_W}), 0);
        chk("rst_rf_wen", int'(rf_wen_W), 0);
        chk("rst_rf_waddr", int'(rf_waddr_W), 0);
        chk("rst_reg_en", int'({reg_en_X, reg_en_M}), 3);
        stall_M = 1'b1;
        #1;
        chk("rst_reg_en_stallM", int'({reg_en_X, reg_en_M}), 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 9'h0);
        @(posedge clk); #1;

`ifdef LAB2_PROC_HAZARD_BYPASS_EN
        add(0,1,0,0,1,RS1|WEN,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,1,1,2,RS1|RS2|WEN,0,1,1,0,0,3,3'b100,0,0);
        idl(0,0,3'b110,0,0);
        idl(0,0,3'b011,1,1);
        idl(0,0,3'b001,1,2);
        add(0,1,0,0,3,RS1|WEN|LD,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,3,0,4,RS1|RS2|WEN,1,1,0,0,0,3,3'b100,0,0);
        add(0,1,3,0,4,RS1|RS2|WEN,0,2,0,0,0,3,3'b010,0,0);
        idl(0,0,3'b101,1,3);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,4);
        add(0,1,1,2,5,RS1|RS2|WEN|MUL|RDY,0,0,0,1,0,3,3'b000,0,0);
        for (int i = 0; i < 3; i++) add(0,1,5,0,6,RS1|WEN,1,1,0,0,1,2'b01,3'b100,0,0);
        add(0,1,5,0,6,RS1|WEN|RSP,0,1,0,0,1,3,3'b100,0,0);
        idl(0,0,3'b110,0,0);
        idl(0,0,3'b011,1,5);
        idl(0,0,3'b001,1,6);
        add(0,1,0,0,7,WEN|MUL,1,0,0,1,0,3,3'b000,0,0);
        add(0,1,0,0,7,WEN|MUL|RDY,0,0,0,1,0,3,3'b000,0,0);
        idl(RSP,1,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,7);
        add(0,1,0,0,3,WEN|LD,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,3,0,8,RS1|WEN|MUL|SQ|RDY,0,1,0,0,0,3,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,3);
        add(0,1,0,0,0,RS1|WEN,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,0,0,9,RS1|RS2|WEN,0,0,0,0,0,3,3'b100,0,0);
        idl(0,0,3'b110,0,0);
        idl(0,0,3'b011,0,0);
        idl(0,0,3'b001,1,9);
        add(0,1,0,0,10,WEN,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,0,0,11,WEN,0,0,0,0,0,3,3'b100,0,0);
        for (int i = 0; i < 3; i++) add(0,1,10,0,12,RS1|WEN|STM,1,2,0,0,0,2'b00,3'b110,0,0);
        add(0,1,10,0,12,RS1|WEN,0,2,0,0,0,3,3'b110,0,0);
        idl(0,0,3'b111,1,10);
        idl(0,0,3'b011,1,11);
        idl(0,0,3'b001,1,12);
`else
        add(0,1,0,0,1,RS1|WEN,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,1,1,2,RS1|RS2|WEN,1,0,0,0,0,3,3'b100,0,0);
        add(0,1,1,1,2,RS1|RS2|WEN,1,0,0,0,0,3,3'b010,0,0);
        add(0,1,1,1,2,RS1|RS2|WEN,1,0,0,0,0,3,3'b001,1,1);
        add(0,1,1,1,2,RS1|RS2|WEN,0,0,0,0,0,3,3'b000,0,0);
        idl(0,0,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,2);
        add(0,1,0,0,3,RS1|WEN|LD,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,3,0,4,RS1|RS2|WEN,1,0,0,0,0,3,3'b100,0,0);
        add(0,1,3,0,4,RS1|RS2|WEN,1,0,0,0,0,3,3'b010,0,0);
        add(0,1,3,0,4,RS1|RS2|WEN,1,0,0,0,0,3,3'b001,1,3);
        add(0,1,3,0,4,RS1|RS2|WEN,0,0,0,0,0,3,3'b000,0,0);
        idl(0,0,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,4);
        add(0,1,1,2,5,RS1|RS2|WEN|MUL|RDY,0,0,0,1,0,3,3'b000,0,0);
        add(0,1,5,0,6,RS1|WEN,1,0,0,0,1,2'b01,3'b100,0,0);
        add(0,1,5,0,6,RS1|WEN,1,0,0,0,1,2'b01,3'b100,0,0);
        add(0,1,5,0,6,RS1|WEN|RSP,1,0,0,0,1,3,3'b100,0,0);
        add(0,1,5,0,6,RS1|WEN,1,0,0,0,0,3,3'b010,0,0);
        add(0,1,5,0,6,RS1|WEN,1,0,0,0,0,3,3'b001,1,5);
        add(0,1,5,0,6,RS1|WEN,0,0,0,0,0,3,3'b000,0,0);
        idl(0,0,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,6);
        add(0,1,0,0,7,WEN|MUL,1,0,0,1,0,3,3'b000,0,0);
        add(0,1,0,0,7,WEN|MUL|RDY,0,0,0,1,0,3,3'b000,0,0);
        idl(RSP,1,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,7);
        add(0,1,0,0,3,WEN|LD,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,3,0,8,RS1|WEN|MUL|SQ|RDY,0,0,0,0,0,3,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,3);
        add(0,1,0,0,0,RS1|WEN,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,0,0,9,RS1|RS2|WEN,0,0,0,0,0,3,3'b100,0,0);
        idl(0,0,3'b110,0,0);
        idl(0,0,3'b011,0,0);
        idl(0,0,3'b001,1,9);
        add(0,1,0,0,10,WEN,0,0,0,0,0,3,3'b000,0,0);
        add(0,1,0,0,11,WEN,0,0,0,0,0,3,3'b100,0,0);
        for (int i = 0; i < 3; i++) add(0,1,10,0,12,RS1|WEN|STM,1,0,0,0,0,2'b00,3'b110,0,0);
        add(0,1,10,0,12,RS1|WEN,1,0,0,0,0,3,3'b110,0,0);
        add(0,1,10,0,12,RS1|WEN,1,0,0,0,0,3,3'b011,1,10);
        add(0,1,10,0,12,RS1|WEN,0,0,0,0,0,3,3'b001,1,11);
        idl(0,0,3'b100,0,0);
        idl(0,0,3'b010,0,0);
        idl(0,0,3'b001,1,12);
`endif
        add(0,1,0,0,13,WEN,0,0,0,0,0,3,3'b000,0,0);
        add(1,1,0,0,14,WEN,0,0,0,0,0,3,3'b100,0,0);
        idl(0,0,3'b000,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].val, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("row%0d_stall_D", i), int'(stall_D), int'(vecs[i].st));
            chk($sformatf("row%0d_sel1", i), int'(bypass_rs1_sel), BYP ? int'(vecs[i].s1) : 0);
            chk($sformatf("row%0d_sel2", i), int'(bypass_rs2_sel), BYP ? int'(vecs[i].s2) : 0);
            chk($sformatf("row%0d_req_val", i), int'(imul_req_val_D), int'(vecs[i].req));
            chk($sformatf("row%0d_resp_rdy", i), int'(imul_resp_rdy_X), int'(vecs[i].rrdy));
            chk($sformatf("row%0d_reg_en", i), int'({reg_en_X, reg_en_M}), int'(vecs[i].en));
            chk($sformatf("row%0d_vals", i), int'({val_X, val_M, val_W}), int'(vecs[i].v));
            chk($sformatf("row%0d_rf_wen", i), int'(rf_wen_W), int'(vecs[i].rfw));
            if (vecs[i].rfw)
                chk($sformatf("row%0d_rf_waddr", i), int'(rf_waddr_W), int'(vecs[i].wa));
            @(posedge clk); #1;
        end

        drive(1, 0, 0, 0, 0, 9'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) pipe[k] = bubble;

        for (int c = 0; c < 3000; c++) begin
            bit [8:0] fl;
            fl[8] = ($urandom_range(0, 9) < 7);
            fl[7] = ($urandom_range(0, 9) < 7);
            fl[6] = ($urandom_range(0, 9) < 8);
            fl[5] = ($urandom_range(0, 3) == 0);
            fl[4] = !fl[5] && ($urandom_range(0, 3) == 0);
            fl[3] = ($urandom_range(0, 9) == 0);
            fl[2] = ($urandom_range(0, 6) == 0);
            fl[1] = ($urandom_range(0, 9) < 7);
            fl[0] = ($urandom_range(0, 9) < 4);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), fl);

            stx     = (pipe[0].v && pipe[0].mul && !imul_resp_val_X) || stall_M;
            rs_a[0] = int'(rs1_D);  en_a[0] = rs1_en_D;
            rs_a[1] = int'(rs2_D);  en_a[1] = rs2_en_D;
            ld_hz   = 0;
            any_hz  = 0;
            for (int j = 0; j < 2; j++) begin
                int found;
                found = -1;
                for (int k = 2; k >= 0; k--)
                    if (en_a[j] && rs_a[j] != 0 && pipe[k].v && pipe[k].wen && pipe[k].rd == rs_a[j])
                        found = k;
                if (found >= 0) any_hz = 1;
                if (found == 0 && pipe[0].ld) ld_hz = 1;
                sel_e[j] = BYP ? found + 1 : 0;
            end
            hz      = BYP ? ld_hz : any_hz;
            sthz_e  = val_D && !squash_D && (stx || hz);
            std_e   = sthz_e || (val_D && !squash_D && is_mul_D && !imul_req_rdy_D);
            req_e   = val_D && is_mul_D && !squash_D && !sthz_e;
            enter_e = val_D && !squash_D && !std_e && !stx;

            @(negedge clk);
            chk($sformatf("rnd%0d_stall_D", c), int'(stall_D), int'(std_e));
            chk($sformatf("rnd%0d_sel1", c), int'(bypass_rs1_sel), sel_e[0]);
            chk($sformatf("rnd%0d_sel2", c), int'(bypass_rs2_sel), sel_e[1]);
            chk($sformatf("rnd%0d_req_val", c), int'(imul_req_val_D), int'(req_e));
            chk($sformatf("rnd%0d_mul_fire", c), int'(imul_req_val_D && imul_req_rdy_D),
                int'(enter_e && is_mul_D));
            chk($sformatf("rnd%0d_resp_rdy", c), int'(imul_resp_rdy_X),
                int'(pipe[0].v && pipe[0].mul && !stall_M));
            chk($sformatf("rnd%0d_reg_en", c), int'({reg_en_X, reg_en_M}), int'({!stx, !stall_M}));
            chk($sformatf("rnd%0d_vals", c), int'({val_X, val_M, val_W}),
                int'({pipe[0].v, pipe[1].v, pipe[2].v}));
            chk($sformatf("rnd%0d_rf_wen", c), int'(rf_wen_W),
                int'(pipe[2].v && pipe[2].wen && pipe[2].rd != 0));
            if (pipe[2].v && pipe[2].wen && pipe[2].rd != 0)
                chk($sformatf("rnd%0d_rf_waddr", c), int'(rf_waddr_W), pipe[2].rd);

            dslot  = '{enter_e, int'(rd_D), wen_D, is_load_D, is_mul_D};
            nxt[2] = stall_M ? bubble : pipe[1];
            nxt[1] = stall_M ? pipe[1] : (stx ? bubble : pipe[0]);
            nxt[0] = stx ? pipe[0] : dslot;
            @(posedge clk);
            for (int k = 0; k < 3; k++) pipe[k] = reset ? bubble : nxt[k];
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab2_proc_hazard_unit.md
# lab2_proc_hazard_unit

Hazard, stall and bypass controller for the 5-stage pipelined TinyRV2 datapath. It shadows the X/M/W stages with valid/destination/type state, drives stall and squash qualification back to D, generates the rs1/rs2 bypass mux selects, and sequences the variable-latency iterative multiplier's request/response handshakes. It sits beside the pipeline control unit: control decodes the instruction, and this block decides when the instruction may leave D and where its operands come from.

## Interface
- p_nregs_log2, 5, register-specifier width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- val_D  in  1  valid instruction in D
- rs1_en_D / rs2_en_D  in  1  instruction reads rs1 / rs2
- rs1_D / rs2_D / rd_D  in  p_nregs_log2  register specifiers
- wen_D  in  1  instruction writes rd
- is_load_D  in  1  instruction is a load
- is_mul_D  in  1  instruction is mul
- squash_D  in  1  kill the instruction in D (taken branch/jalr in X, jal in D)
- stall_M  in  1  M cannot advance (dmem response not yet valid)
- imul_req_rdy_D  in  1  multiplier accepts operands
- imul_resp_val_X  in  1  multiplier result valid
- stall_D  out  1  hold F/D registers
- bypass_rs1_sel / bypass_rs2_sel  out  2  0 = rf, 1 = X, 2 = M, 3 = W
- imul_req_val_D  out  1  multiplier request valid
- imul_resp_rdy_X  out  1  multiplier response ready
- reg_en_X / reg_en_M  out  1  advance X / M registers
- val_X / val_M / val_W  out  1  stage valid bits
- rf_wen_W  out  1  register-file write enable
- rf_waddr_W  out  p_nregs_log2  register-file write address

## Operation
- Internal per-stage state: X {val, rd, wen, is_load, is_mul}, M {val, rd, wen}, W {val, rd, wen}.
- Advance rules:
  - stall_X = val_X & is_mul_X & !imul_resp_val_X | stall_M.
  - W always loads from M; it loads a bubble when stall_M.
  - M loads from X when !stall_M; it loads a bubble when stall_X & !stall_M.
  - X loads from D when !stall_X; it loads a bubble when stall_D or squash_D.
- reg_en_X = !stall_X; reg_en_M = !stall_M.
- Hazard match: a stage matches a source when val_S & wen_S & rd_S == rs & rs != 0 & rs_en.
- stall_D = val_D & !squash_D & (stall_X | load-use | mul-busy).
  - load-use: a source matches X and is_load_X.
  - mul-busy: is_mul_D & !imul_req_rdy_D.
- stall_hz is stall_D with the mul-busy term removed.
- Bypass select: youngest matching stage wins, priority X > M > W; no match gives 0.
- imul_req_val_D = val_D & is_mul_D & !squash_D & !stall_hz. It never depends on imul_req_rdy_D, so there is no combinational loop.
- imul_resp_rdy_X = val_X & is_mul_X & !stall_M.
- rf_wen_W = val_W & wen_W & rd_W != 0; rf_waddr_W = rd_W.
- Squash has priority over stall: when squash_D and stall_D would both be asserted, stall_D = 0 and the D instruction becomes a bubble.

## Timing
- All outputs are combinational from registered stage state plus D-stage inputs. Stage state updates on the posedge.
- Reset: all val bits = 0, stall_D = 0, selects = 0, imul_req_val_D = 0, imul_resp_rdy_X = 0, rf_wen_W = 0, rf_waddr_W = 0, reg_en_X = reg_en_M = 1 (unless stall_M).
- Reset asserted mid-operation clears all stage state in one cycle. An in-flight multiply result is discarded: the multiplier is reset by the same reset.
- Latencies:
  - ALU RAW dependence: 0 stall cycles.
  - Load-use dependence: 1 stall cycle, then bypass from M.
  - Mul-use dependence: the consumer stalls while X holds the mul, then bypasses from X in the cycle imul_resp_val_X rises.
- Multiplier handshakes: a request fires on val & rdy in D; a response fires on val & rdy in X. Exactly one request per mul instruction, including under repeated stalls.

## Configuration
- LAB2_PROC_HAZARD_BYPASS_EN defined: bypassing as described above.
- LAB2_PROC_HAZARD_BYPASS_EN undefined:
  - Both selects are tied to 0.
  - Any source match in X, M or W asserts stall_D. W is included because the register file writes at the clock edge.
  - The load-use and mul-busy terms still apply.
  - An ALU RAW dependence costs 3 stall cycles.

## Test plan
- add x1 ← x0+5, then add x2 ← x1+x1 back-to-back -> bypass_rs1_sel = bypass_rs2_sel = 1, stall_D = 0, x2 = 10.
- lw x3, then add x4 ← x3+x0 -> stall_D high for exactly 1 cycle, then bypass_rs1_sel = 2.
- mul with 4-cycle multiplier latency, then a dependent add -> imul_req_val_D fires once, stall_D held until imul_resp_val_X, then bypass_rs1_sel = 1.
- Taken branch in X with squash_D = 1 while a load-use stall is pending -> stall_D = 0, val_X = 0 next cycle, no imul request issued.
- Write to x0, then read x0 -> selects = 0, rf_wen_W = 0.
- stall_M held 3 cycles with producers in X and M -> X and M hold their contents, W receives 3 bubbles, val_W = 0 for those cycles.
- Bypass disabled: ALU RAW pair -> stall_D for 3 cycles, selects always 0.
